// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the shared-ALU controller.
//   OP_* : op-select encodings understood by the external combinational ALU
//          (any other value is a pass-through of operand A).
//   state_e : controller FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_HALF = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- 2-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   valid[1:0] : request lines
//   advance    : grant is being taken this cycle; update the pointer
//   grant[1:0] : one-hot grant (zero when nothing is valid)
// A lone requester always wins; on a tie the requester that did not win
// last time gets it. Reset treats requester 1 as the last winner so that
// requester 0 takes the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;  // 1: requester 1 granted most recently

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  last <= 1'b1;
    else if (advance && |grant)  last <= grant[1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl -- shares one external combinational ALU between two
// requesters. One op in flight at a time: IDLE (grant + latch operands),
// EXEC (ALU driven from latches, result captured), RESP (hold result until
// consumed). Back-to-back throughput is one op per three cycles.
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready [1:0]  : per-requester handshake (ready one-hot or 0)
//   req_a, req_b [1:0][WIDTH]  : per-requester operands
//   req_sel [1:0][W_ALU_SEL]   : per-requester op select (passed unchecked)
//   rsp_valid/rsp_ready        : result handshake
//   rsp_id, rsp_data           : owning requester, captured result
//   rsp_flag_n, rsp_flag_z     : captured negative / zero flags
//   alu_bus_a/b, alu_sel       : drive to the shared ALU (hold last latch)
//   alu_out, alu_flag_n/c      : ALU result and flags (flag_c = zero)
//   op_count [1:0][16]         : only with ALU_SHARE_CTRL_OP_CNT_EN defined;
//                                saturating per-requester response counts
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int W_ALU_SEL = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0][WIDTH-1:0]     req_a,
  input  logic [1:0][WIDTH-1:0]     req_b,
  input  logic [1:0][W_ALU_SEL-1:0] req_sel,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      rsp_flag_n,
  output logic                      rsp_flag_z,
  output logic [WIDTH-1:0]          alu_bus_a,
  output logic [WIDTH-1:0]          alu_bus_b,
  output logic [W_ALU_SEL-1:0]      alu_sel,
  input  logic [WIDTH-1:0]          alu_out,
  input  logic                      alu_flag_n,
  input  logic                      alu_flag_c
`ifdef ALU_SHARE_CTRL_OP_CNT_EN
  ,
  output logic [1:0][15:0]          op_count
`endif
);

  state_e     state, state_nxt;
  logic [1:0] grant;
  logic       accept;
  logic       gid;
  logic       rsp_fire;

  assign accept   = (state == ST_IDLE) && |req_valid;
  assign gid      = grant[1];
  assign rsp_fire = rsp_valid && rsp_ready;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = grant;
        if (|req_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latches double as the ALU drive, so the ALU inputs only move on
  // an accept edge and never follow the requester buses directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_bus_a <= '0;
      alu_bus_b <= '0;
      alu_sel   <= '0;
      rsp_id    <= 1'b0;
    end else if (accept) begin
      alu_bus_a <= req_a[gid];
      alu_bus_b <= req_b[gid];
      alu_sel   <= req_sel[gid];
      rsp_id    <= gid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data   <= '0;
      rsp_flag_n <= 1'b0;
      rsp_flag_z <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_data   <= alu_out;
      rsp_flag_n <= alu_flag_n;
      rsp_flag_z <= alu_flag_c;
    end
  end

`ifdef ALU_SHARE_CTRL_OP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_fire) begin
      for (int i = 0; i < 2; i++)
        if (rsp_id == i[0] && op_count[i] != 16'hFFFF)
          op_count[i] <= op_count[i] + 16'd1;
    end
  end
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
`endif

endmodule
